alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage that consumes the 4-bit ALU control code and halt flag produced by the ALU decoder.
//  Performs add/sub/logic/cmp/mov in one cycle, shifts iteratively (1 bit/cycle), and IN/OUT
//  via valid/ready handshakes. Reports result, write-enable and SZCV flags with a done pulse.
//  Sits between the register-file read stage and write-back in the multi-cycle datapath.
// PARAMETERS
//  W   16  datapath width (>=4); SW = $clog2(W) derived, shift-amount width
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst_n      in   1     synchronous active-low reset
//  start      in   1     issue op; accepted only when busy=0
//  alucontrol in   4     op code (0000 add..1101 out; 0111/1110/1111 illegal)
//  halt       in   1     decoder halt request
//  a, b       in   W     operands (a = rd value, b = rs/imm value)
//  shamt      in   SW    shift distance
//  busy       out  1     op in flight or halted
//  done       out  1     1-cycle pulse, result/wr_en/flags_we valid this cycle
//  result     out  W     write-back data
//  wr_en      out  1     qualifies result for write-back (only with done)
//  flags      out  4     {S,Z,C,V} registered flag register
//  flags_we   out  1     pulse with done when flags were updated
//  illegal    out  1     pulse with done for reserved code
//  halted     out  1     sticky halt status
//  in_data    in   W     external input word
//  in_valid   in   1     in_data valid
//  in_ready   out  1     unit accepting in_data
//  out_data   out  W     external output word (= b at issue)
//  out_valid  out  1     out_data valid; held until out_ready
//  out_ready  in   1     consumer accepts out_data
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE; all outputs 0 incl. flags, result, halted.
//  States: IDLE, SHIFT, IN_WAIT, OUT_WAIT, DONE, HALTED. busy=1 in all but IDLE.
//  IDLE: halt=1 -> HALTED (start ignored, same cycle). Else start=1 at edge t latches a,b,shamt,code:
//   ALU/illegal -> DONE; shift shamt=0 -> DONE; shift shamt>0 -> SHIFT (cnt=shamt); in -> IN_WAIT;
//   out -> OUT_WAIT.
//  DONE: done=1 for exactly one cycle, then IDLE (or HALTED if halt=1 in DONE).
//  Latency: ALU op done at t+1; shift done at t+1+shamt; IN/OUT done one cycle after handshake.
//  SHIFT: one bit per cycle, cnt decrements; cnt reaching 0 -> DONE. sll/srl fill 0; sra fills
//   MSB; slr rotates left. C = last bit shifted out (0 when shamt=0); V=0; S,Z from result.
//  IN_WAIT: in_ready=1; in_valid&in_ready -> capture in_data as result, -> DONE.
//  OUT_WAIT: out_valid=1, out_data stable; out_valid&out_ready -> DONE. Never drops unaccepted.
//  Arithmetic mod 2^W. add: C=carry out, V=signed ovf. sub/cmp: a-b, C=borrow (a<b unsigned),
//   V=signed ovf. and/or/xor/mov(=b): C=V=0. S=result[W-1], Z=(result==0).
//  wr_en=1 for add,sub,and,or,xor,mov,shifts,in. cmp/out/illegal: wr_en=0.
//  flags_we=1 for all except in, out, illegal (flags hold).
//  illegal (0111,1110,1111): result=0, illegal=1 with done.
//  halt while busy: current op completes normally, then HALTED. HALTED is sticky until reset.
//  start while busy: ignored, no queuing. rst_n=0 mid-op: abandon op, no done pulse.
// STRUCTURE
//  Package alu_pkg: ALU_ADD..ALU_OUT code constants, state encoding, flag bit indices.
//  Sub-module alu_shift_step: combinational 1-bit shift/rotate (code, value) -> (value, carry).
// TESTING
//  W=16, add a=0x7FFF b=0x0001 -> done at t+1, result 0x8000, wr_en=1, flags S=1 Z=0 C=0 V=1.
//  cmp a=0x0003 b=0x0005 -> wr_en=0, flags_we=1, S=1 C=1 Z=0 V=0; result not written.
//  sra a=0x8001 shamt=3 -> done at t+4, result 0xF000, C=0; shamt=0 -> done t+1, C=0.
//  out b=0x1234, hold out_ready=0 5 cycles -> out_valid held, data stable; done 1 cycle after ready.
//  in with in_valid late by 3 cycles -> result=in_data, wr_en=1, flags unchanged.
//  halt during SHIFT -> shift finishes with done, then halted=1, busy=1, starts ignored until rst_n.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and flag bit positions for the ALU execute stage.
package alu_pkg;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;
  localparam logic [3:0] AluXor = 4'b0100;
  localparam logic [3:0] AluMov = 4'b0101;
  localparam logic [3:0] AluCmp = 4'b0110;
  localparam logic [3:0] AluSll = 4'b1000;
  localparam logic [3:0] AluSrl = 4'b1001;
  localparam logic [3:0] AluSra = 4'b1010;
  localparam logic [3:0] AluSlr = 4'b1011;
  localparam logic [3:0] AluIn  = 4'b1100;
  localparam logic [3:0] AluOut = 4'b1101;

  localparam int unsigned FlagS = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StShift   = 3'd1,
    StInWait  = 3'd2,
    StOutWait = 3'd3,
    StDone    = 3'd4,
    StHalted  = 3'd5
  } state_e;

  function automatic logic is_shift(input logic [3:0] code);
    return code[3:2] == 2'b10;
  endfunction

  function automatic logic is_illegal(input logic [3:0] code);
    return (code == 4'b0111) || (code == 4'b1110) || (code == 4'b1111);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Single-bit shift/rotate step; carry_o is the bit shifted out.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [3:0]   code_i,
  input  logic [W-1:0] value_i,
  output logic [W-1:0] value_o,
  output logic         carry_o
);

  always_comb begin
    value_o = value_i;
    carry_o = 1'b0;
    case (code_i)
      AluSll: begin
        value_o = {value_i[W-2:0], 1'b0};
        carry_o = value_i[W-1];
      end
      AluSrl: begin
        value_o = {1'b0, value_i[W-1:1]};
        carry_o = value_i[0];
      end
      AluSra: begin
        value_o = {value_i[W-1], value_i[W-1:1]};
        carry_o = value_i[0];
      end
      AluSlr: begin
        value_o = {value_i[W-2:0], value_i[W-1]};
        carry_o = value_i[W-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ALU ops, iterative shifts, and IN/OUT handshakes, with SZCV flags.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [3:0]           alucontrol_i,
  input  logic                 halt_i,
  input  logic [W-1:0]         a_i,
  input  logic [W-1:0]         b_i,
  input  logic [$clog2(W)-1:0] shamt_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [W-1:0]         result_o,
  output logic                 wr_en_o,
  output logic [3:0]           flags_o,
  output logic                 flags_we_o,
  output logic                 illegal_o,
  output logic                 halted_o,
  input  logic [W-1:0]         in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [W-1:0]         out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i
);

  localparam int unsigned SW = $clog2(W);

  state_e         state_q;
  logic [3:0]     code_q;
  logic [SW-1:0]  cnt_q;
  logic [W-1:0]   result_q, out_q;
  logic [3:0]     flags_q;
  logic           busy_q, done_q, wr_en_q, flags_we_q, illegal_q, halted_q;
  logic           in_ready_q, out_valid_q;

  logic [W:0]     sum, diff;
  logic [W-1:0]   alu_res;
  logic           alu_c, alu_v;
  logic [3:0]     alu_flags;
  logic [W-1:0]   step_val;
  logic           step_c;

  always_comb begin
    sum     = {1'b0, a_i} + {1'b0, b_i};
    diff    = {1'b0, a_i} - {1'b0, b_i};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alucontrol_i)
      AluAdd: begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      AluSub, AluCmp: begin
        // diff[W] is set exactly when a < b unsigned, i.e. the borrow
        alu_res = diff[W-1:0];
        alu_c   = diff[W];
        alu_v   = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
      end
      AluAnd:  alu_res = a_i & b_i;
      AluOr:   alu_res = a_i | b_i;
      AluXor:  alu_res = a_i ^ b_i;
      AluMov:  alu_res = b_i;
      default: ;
    endcase
    alu_flags = {alu_res[W-1], alu_res == '0, alu_c, alu_v};
  end

  alu_shift_step #(
    .W(W)
  ) u_shift_step (
    .code_i  (code_q),
    .value_i (result_q),
    .value_o (step_val),
    .carry_o (step_c)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      code_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_q       <= '0;
      flags_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      flags_we_q  <= 1'b0;
      illegal_q   <= 1'b0;
      halted_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      flags_we_q <= 1'b0;
      illegal_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (halt_i) begin
            state_q  <= StHalted;
            busy_q   <= 1'b1;
            halted_q <= 1'b1;
          end else if (start_i) begin
            code_q <= alucontrol_i;
            busy_q <= 1'b1;
            if (is_shift(alucontrol_i)) begin
              result_q <= a_i;
              cnt_q    <= shamt_i;
              if (shamt_i == '0) begin
                state_q    <= StDone;
                done_q     <= 1'b1;
                wr_en_q    <= 1'b1;
                flags_we_q <= 1'b1;
                flags_q    <= {a_i[W-1], a_i == '0, 1'b0, 1'b0};
              end else begin
                state_q <= StShift;
              end
            end else if (alucontrol_i == AluIn) begin
              state_q    <= StInWait;
              in_ready_q <= 1'b1;
            end else if (alucontrol_i == AluOut) begin
              state_q     <= StOutWait;
              out_q       <= b_i;
              out_valid_q <= 1'b1;
            end else if (is_illegal(alucontrol_i)) begin
              state_q   <= StDone;
              result_q  <= '0;
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
            end else begin
              state_q    <= StDone;
              result_q   <= alu_res;
              flags_q    <= alu_flags;
              done_q     <= 1'b1;
              wr_en_q    <= (alucontrol_i != AluCmp);
              flags_we_q <= 1'b1;
            end
          end
        end
        StShift: begin
          result_q <= step_val;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == SW'(1)) begin
            state_q    <= StDone;
            done_q     <= 1'b1;
            wr_en_q    <= 1'b1;
            flags_we_q <= 1'b1;
            flags_q    <= {step_val[W-1], step_val == '0, step_c, 1'b0};
          end
        end
        StInWait: begin
          if (in_valid_i) begin
            state_q    <= StDone;
            result_q   <= in_data_i;
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
            wr_en_q    <= 1'b1;
          end
        end
        StOutWait: begin
          if (out_ready_i) begin
            state_q     <= StDone;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        StDone: begin
          if (halt_i) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StHalted: ;
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign wr_en_o     = wr_en_q;
  assign flags_o     = flags_q;
  assign flags_we_o  = flags_we_q;
  assign illegal_o   = illegal_q;
  assign halted_o    = halted_q;
  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver queues expected responses, monitor checks on done.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         chk_res;
    logic         we;
    logic         fwe;
    logic         ill;
    logic [3:0]   flags;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, start, halt, in_valid, out_ready;
  logic [3:0]   alucontrol;
  logic [W-1:0] op_a, op_b, in_data;
  logic [3:0]   shamt;
  logic         busy_o, done_o, wr_en_o, flags_we_o, illegal_o, halted_o, in_ready_o, out_valid_o;
  logic [W-1:0] result_o, out_data_o;
  logic [3:0]   flags_o;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [3:0] cur_flags = 4'b0000;
  exp_t       exp_q[$];
  exp_t       mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_exec_unit #(
    .W(W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .alucontrol_i (alucontrol),
    .halt_i       (halt),
    .a_i          (op_a),
    .b_i          (op_b),
    .shamt_i      (shamt),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .wr_en_o      (wr_en_o),
    .flags_o      (flags_o),
    .flags_we_o   (flags_we_o),
    .illegal_o    (illegal_o),
    .halted_o     (halted_o),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready_o),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_cycle", cyc, mon_e.cyc);
          if (mon_e.chk_res) chk("result", result_o, mon_e.res);
          chk("wr_en", wr_en_o, mon_e.we);
          chk("flags_we", flags_we_o, mon_e.fwe);
          chk("illegal", illegal_o, mon_e.ill);
          chk("flags", flags_o, mon_e.flags);
        end
      end else begin
        chk("pulses_without_done", {wr_en_o, flags_we_o, illegal_o}, 3'b000);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [W-1:0] res, input logic we, input logic fwe,
                          input logic ill, input logic [3:0] fl, input int lat);
    exp_t e;
    if (fwe) cur_flags = fl;
    e.res     = res;
    e.chk_res = we | ill;
    e.we      = we;
    e.fwe     = fwe;
    e.ill     = ill;
    e.flags   = cur_flags;
    e.cyc     = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic run_op(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] sh, input logic [W-1:0] res, input logic we,
                        input logic fwe, input logic ill, input logic [3:0] fl, input int lat);
    @(negedge clk);
    push_exp(res, we, fwe, ill, fl, lat);
    alucontrol = code;
    op_a       = a;
    op_b       = b;
    shamt      = sh;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alucontrol = '0; op_a = '0; op_b = '0; in_data = '0; shamt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_result", result_o, '0);
    chk("rst_flags", flags_o, 4'b0000);
    chk("rst_halted", halted_o, 1'b0);
    chk("rst_handshake", {in_ready_o, out_valid_o, wr_en_o}, 3'b000);
    rst_n = 1'b1;

    // code, a, b, shamt, result, wr_en, flags_we, illegal, flags {S,Z,C,V}, latency
    run_op(AluAdd, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 1, 1, 0, 4'b1001, 1);
    run_op(AluCmp, 16'h0003, 16'h0005, 4'd0, 16'h0000, 0, 1, 0, 4'b1010, 1);
    run_op(AluSub, 16'h0005, 16'h0005, 4'd0, 16'h0000, 1, 1, 0, 4'b0100, 1);
    run_op(AluSub, 16'h8000, 16'h0001, 4'd0, 16'h7FFF, 1, 1, 0, 4'b0001, 1);
    run_op(AluAdd, 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 1, 1, 0, 4'b0110, 1);
    run_op(AluAnd, 16'hF0F0, 16'h3C3C, 4'd0, 16'h3030, 1, 1, 0, 4'b0000, 1);
    run_op(AluOr,  16'h0F00, 16'h00F0, 4'd0, 16'h0FF0, 1, 1, 0, 4'b0000, 1);
    run_op(AluXor, 16'h8000, 16'h0001, 4'd0, 16'h8001, 1, 1, 0, 4'b1000, 1);
    run_op(AluMov, 16'h1234, 16'h0000, 4'd0, 16'h0000, 1, 1, 0, 4'b0100, 1);
    run_op(AluSll, 16'h8001, 16'h0000, 4'd1, 16'h0002, 1, 1, 0, 4'b0010, 2);
    run_op(AluSrl, 16'h0003, 16'h0000, 4'd2, 16'h0000, 1, 1, 0, 4'b0110, 3);
    run_op(AluSra, 16'h8001, 16'h0000, 4'd3, 16'hF000, 1, 1, 0, 4'b1000, 4);
    run_op(AluSra, 16'h8001, 16'h0000, 4'd0, 16'h8001, 1, 1, 0, 4'b1000, 1);
    run_op(AluSlr, 16'h8001, 16'h0000, 4'd4, 16'h0018, 1, 1, 0, 4'b0000, 5);
    run_op(AluSlr, 16'h8001, 16'h0000, 4'd1, 16'h0003, 1, 1, 0, 4'b0010, 2);
    run_op(4'b0111, 16'h1111, 16'h2222, 4'd0, 16'h0000, 0, 0, 1, 4'b0000, 1);
    run_op(4'b1111, 16'h1111, 16'h2222, 4'd0, 16'h0000, 0, 0, 1, 4'b0000, 1);

    // OUT held off for 5 cycles; a start during the wait must be ignored
    @(negedge clk);
    alucontrol = AluOut; op_b = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_b = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      chk("out_valid_held", out_valid_o, 1'b1);
      chk("out_data_stable", out_data_o, 16'h1234);
      start      = (i == 1);
      alucontrol = AluAdd;
      @(negedge clk);
    end
    start = 1'b0;
    push_exp(16'h0000, 0, 0, 0, 4'b0000, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_dropped", out_valid_o, 1'b0);
    drain();

    // IN with in_valid arriving 3 cycles late
    @(negedge clk);
    alucontrol = AluIn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      chk("in_ready", in_ready_o, 1'b1);
      @(negedge clk);
    end
    push_exp(16'hBEEF, 1, 0, 0, 4'b0000, 1);
    in_data = 16'hBEEF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Reset mid-shift abandons the op without a done pulse
    alucontrol = AluSra; op_a = 16'h8001; shamt = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midop_rst_busy", busy_o, 1'b0);
    chk("midop_rst_flags", flags_o, 4'b0000);
    cur_flags = 4'b0000;
    repeat (8) @(negedge clk);

    // Halt during SHIFT: shift completes, then sticky HALTED
    push_exp(16'h0008, 1, 1, 0, 4'b0000, 4);
    alucontrol = AluSll; op_a = 16'h0001; shamt = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; halt = 1'b1;
    drain();
    chk("halted_set", halted_o, 1'b1);
    chk("halted_busy", busy_o, 1'b1);
    halt = 1'b0;
    alucontrol = AluAdd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("halted_sticky", halted_o, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("unhalt_halted", halted_o, 1'b0);
    chk("unhalt_busy", busy_o, 1'b0);
    chk("unhalt_result", result_o, '0);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
